// File: rtl/mdu_unit.sv
// Multiply/divide unit with HI/LO registers for the execute stage.
// Each accepted MULT/MULTU/DIV/DIVU computes its 64-bit result right away and
// holds it in a pending register. A down-counter models the fixed latency.
// HI/LO are written on the edge where the counter reaches zero.
module mdu_unit #(
    parameter int unsigned MUL_LAT = 5,
    parameter int unsigned DIV_LAT = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        Start,
    input  logic [3:0]  MDUCtrl,
    input  logic [31:0] SrcA,
    input  logic [31:0] SrcB,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDUResult
);

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [63:0] res_q, res_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic [63:0] prod_s, prod_u, div_res;
    logic        div_signed, a_neg, b_neg;
    logic [31:0] a_mag, b_mag, q_mag, r_mag, quo, rem;

    // Arithmetic datapath: both products, plus one divider shared by DIV/DIVU.
    // Signed division runs on magnitudes and then restores the signs, so the
    // 0x80000000 / -1 overflow case yields 0x80000000 with remainder 0.
    always_comb begin
        prod_u     = {32'b0, SrcA} * {32'b0, SrcB};
        prod_s     = {{32{SrcA[31]}}, SrcA} * {{32{SrcB[31]}}, SrcB};
        div_signed = (MDUCtrl == 4'd2);
        a_neg      = div_signed & SrcA[31];
        b_neg      = div_signed & SrcB[31];
        a_mag      = a_neg ? (~SrcA + 32'd1) : SrcA;
        b_mag      = b_neg ? (~SrcB + 32'd1) : SrcB;
        q_mag      = '0;
        r_mag      = '0;
        if (b_mag != '0) begin
            q_mag = a_mag / b_mag;
            r_mag = a_mag % b_mag;
        end
        quo        = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
        rem        = a_neg ? (~r_mag + 32'd1) : r_mag;
        div_res    = (SrcB == '0) ? {SrcA, 32'hFFFF_FFFF} : {rem, quo};
    end

    // Next-state logic: accept/move-to ops when idle, count down while busy.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    case (MDUCtrl)
                        4'd0: begin res_d = prod_s;  cnt_d = 4'(MUL_LAT); state_d = S_BUSY; end
                        4'd1: begin res_d = prod_u;  cnt_d = 4'(MUL_LAT); state_d = S_BUSY; end
                        4'd2,
                        4'd3: begin res_d = div_res; cnt_d = 4'(DIV_LAT); state_d = S_BUSY; end
                        4'd6: hi_d = SrcA;
                        4'd7: lo_d = SrcA;
                        default: ;
                    endcase
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    hi_d    = res_q[63:32];
                    lo_d    = res_q[31:0];
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            res_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Combinational MFHI/MFLO read port.
    always_comb begin
        case (MDUCtrl)
            4'd4:    MDUResult = hi_q;
            4'd5:    MDUResult = lo_q;
            default: MDUResult = '0;
        endcase
    end

    assign Busy = (state_q == S_BUSY);
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule
